peripheral_arbiter_wb: RTL and testbench
========================================

PERIPHERAL_ARBITER_WB -- requirements
Module: peripheral_arbiter_wb

Interface
REQ-001 SHALL have parameter MASTERS, default 4, number of requesting Wishbone masters (2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width; select width is DW/8.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum cycles a granted access waits for ack/err.
REQ-005 SHALL have one clock and a synchronous, active-high reset, as specified in REQ-006 and REQ-007.
REQ-006 SHALL have port aclk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port areset, input, 1 bit, the synchronous, active-high reset.
REQ-008 SHALL have port m_cyc_i, input, MASTERS bits, the per-master cycle request.
REQ-009 SHALL have port m_stb_i, input, MASTERS bits, the per-master strobe.
REQ-010 SHALL have port m_we_i, input, MASTERS bits, the per-master write enable.
REQ-011 SHALL have port m_adr_i, input, MASTERS*AW bits, packed per-master addresses, master i at slice [i*AW +: AW].
REQ-012 SHALL have port m_dat_i, input, MASTERS*DW bits, packed per-master write data.
REQ-013 SHALL have port m_sel_i, input, MASTERS*DW/8 bits, packed per-master byte selects.
REQ-014 SHALL have port m_dat_o, output, DW bits, read data broadcast to all masters.
REQ-015 SHALL have port m_ack_o, output, MASTERS bits, per-master acknowledge.
REQ-016 SHALL have port m_err_o, output, MASTERS bits, per-master error.
REQ-017 SHALL have ports s_cyc_o/s_stb_o/s_we_o, outputs, 1 bit each, the slave-side control.
REQ-018 SHALL have ports s_adr_o (AW), s_dat_o (DW) and s_sel_o (DW/8), outputs, the slave-side address, write data and selects.
REQ-019 SHALL have ports s_dat_i (DW), s_ack_i (1) and s_err_i (1), inputs, the slave-side read data and response.
REQ-020 SHALL have port grant_o, output, MASTERS bits, one-hot current owner, all-zero when idle.

Function
REQ-021 SHALL implement FSM states IDLE and OWNED.
REQ-022 In IDLE with any m_cyc_i set, SHALL register grant to the first requester found searching upward from (last_owner+1) mod MASTERS, with wrap-around, and go to OWNED next cycle; one cycle grant latency.
REQ-023 In IDLE with no request, SHALL stay IDLE with grant_o=0.
REQ-024 In OWNED, SHALL route the owner's cyc/stb/we/adr/dat/sel combinationally to the slave side.
REQ-025 SHALL route s_ack_i/s_err_i only to the owner's m_ack_o/m_err_o; all other masters see 0.
REQ-026 s_cyc_o and s_stb_o SHALL be 0 whenever the FSM is IDLE.
REQ-027 Ownership SHALL persist across multiple stb beats while the owner holds m_cyc_i, giving burst/locked access.
REQ-028 When the owner drops m_cyc_i, SHALL return to IDLE, update last_owner and deassert grant_o next cycle; re-arbitration takes effect one cycle after that (minimum 1 idle cycle between owners).
REQ-029 Requests arriving while OWNED SHALL NOT preempt; they are served in round-robin order afterwards.
REQ-030 SHALL use an 8-bit-or-wider watchdog counter that clears on entering OWNED, on each ack/err and while stb is low, and increments while owner stb=1 without ack/err.
REQ-031 When the counter reaches TIMEOUT, SHALL pulse m_err_o of the owner for 1 cycle, force s_cyc_o=0 that cycle and return to IDLE.
REQ-032 Simultaneous s_ack_i and s_err_i SHALL forward err only.
REQ-033 m_dat_o SHALL equal s_dat_i at all times.

Reset
REQ-034 On areset=1 at a clock edge, SHALL enter IDLE, set grant_o=0 and last_owner=MASTERS-1 (so master 0 has first priority), and clear the watchdog.
REQ-035 While in reset, s_cyc_o, s_stb_o, m_ack_o and m_err_o SHALL be 0.
REQ-036 Reset mid-transfer SHALL abort the cycle immediately, with no ack/err delivered.

Verification
REQ-037 Bench SHALL check: after reset, m_cyc_i=4'b1111 -> grants in order 0,1,2,3,0, each separated by 1 idle cycle.
REQ-038 Bench SHALL check: master 2 holds cyc for a 4-beat burst while master 1 requests -> grant_o=4'b0100 for all 4 acks, then 4'b0010.
REQ-039 Bench SHALL check: master 3 writes adr 0x1000 dat 0xDEADBEEF sel 4'hF -> slave sees identical values; only m_ack_o[3] pulses.
REQ-040 Bench SHALL check: slave never acks with TIMEOUT=255 -> m_err_o[owner]=1 exactly 255 cycles after stb, then IDLE.
REQ-041 Bench SHALL check: s_ack_i and s_err_i both 1 -> m_err_o=1 and m_ack_o=0 for the owner.
REQ-042 Bench SHALL check: areset asserted during OWNED -> next cycle grant_o=0 and s_cyc_o=0; the next grant goes to master 0.

Source files
------------

// File: rtl/peripheral_arbiter_wb.sv
// Round-robin Wishbone arbiter: MASTERS requesters share one slave port.
// The owner keeps the bus for as long as it holds cyc (locked/burst access).
// A watchdog aborts an access that the slave never answers.
module peripheral_arbiter_wb #(
  parameter int MASTERS = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [MASTERS-1:0]       m_cyc_i,
  input  logic [MASTERS-1:0]       m_stb_i,
  input  logic [MASTERS-1:0]       m_we_i,
  input  logic [MASTERS*AW-1:0]    m_adr_i,
  input  logic [MASTERS*DW-1:0]    m_dat_i,
  input  logic [MASTERS*DW/8-1:0]  m_sel_i,
  output logic [DW-1:0]            m_dat_o,
  output logic [MASTERS-1:0]       m_ack_o,
  output logic [MASTERS-1:0]       m_err_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic [AW-1:0]            s_adr_o,
  output logic [DW-1:0]            s_dat_o,
  output logic [DW/8-1:0]          s_sel_o,
  input  logic [DW-1:0]            s_dat_i,
  input  logic                     s_ack_i,
  input  logic                     s_err_i,
  output logic [MASTERS-1:0]       grant_o
);

  localparam int SW  = DW / 8;
  localparam int OW  = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int WDW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t             state;
  logic [OW-1:0]      owner;
  logic [OW-1:0]      last_owner;
  logic [MASTERS-1:0] grant;
  logic [WDW-1:0]     wdog;

  logic               pick_vld;
  logic [OW-1:0]      pick_idx;
  logic [OW:0]        cand;

  logic               own_cyc;
  logic               own_stb;
  logic               own_we;
  logic [AW-1:0]      own_adr;
  logic [DW-1:0]      own_dat;
  logic [SW-1:0]      own_sel;

  logic               owned;
  logic               timeout_hit;
  logic               resp_ok;
  logic               fwd_ack;
  logic               fwd_err;

  assign owned       = (state == OWNED);
  assign timeout_hit = owned && (wdog == WDW'(TIMEOUT));

  // Round-robin pick: nearest requester above last_owner, wrapping; the
  // loop runs from the farthest candidate down so the nearest one wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = MASTERS; k >= 1; k--) begin
      cand = {1'b0, last_owner} + (OW+1)'(k);
      if (cand >= (OW+1)'(MASTERS)) cand = cand - (OW+1)'(MASTERS);
      if (m_cyc_i[cand[OW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[OW-1:0];
      end
    end
  end

  // Select the current owner's request signals out of the packed buses.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (owner == OW'(i)) begin
        own_cyc = m_cyc_i[i];
        own_stb = m_stb_i[i];
        own_we  = m_we_i[i];
        own_adr = m_adr_i[i*AW +: AW];
        own_dat = m_dat_i[i*DW +: DW];
        own_sel = m_sel_i[i*SW +: SW];
      end
    end
  end

  // Slave-side drive: cyc/stb are suppressed when idle, in reset and in the
  // watchdog abort cycle; address/data/select simply follow the owner.
  always_comb begin
    s_cyc_o = owned && own_cyc && !timeout_hit && !areset;
    s_stb_o = s_cyc_o && own_stb;
    s_we_o  = own_we;
    s_adr_o = own_adr;
    s_dat_o = own_dat;
    s_sel_o = own_sel;
  end

  // Response steering: only the owner sees ack/err; err beats ack, and a
  // watchdog expiry is reported as err.
  always_comb begin
    resp_ok = owned && !areset;
    fwd_err = resp_ok && (s_err_i || timeout_hit);
    fwd_ack = resp_ok && s_ack_i && !s_err_i && !timeout_hit;
    m_ack_o = '0;
    m_err_o = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (owner == OW'(i)) begin
        m_ack_o[i] = fwd_ack;
        m_err_o[i] = fwd_err;
      end
    end
  end

  assign m_dat_o = s_dat_i;
  assign grant_o = grant;

  // Ownership FSM with registered grant, last-owner pointer and watchdog.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= OW'(MASTERS - 1);
      last_owner <= OW'(MASTERS - 1);
      wdog       <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (pick_vld) begin
            state <= OWNED;
            owner <= pick_idx;
            grant <= MASTERS'(1) << pick_idx;
          end
        end
        OWNED: begin
          if (!own_cyc || timeout_hit) begin
            state      <= IDLE;
            grant      <= '0;
            last_owner <= owner;
            wdog       <= '0;
          end else if (!own_stb || s_ack_i || s_err_i) begin
            wdog <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          wdog  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
// Bench for peripheral_arbiter_wb: directed sequences, a response vector
// table and randomized transactions against a round-robin reference model.
module tb_peripheral_arbiter_wb;

  localparam int M  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 255;

  logic              aclk = 1'b0;
  logic              areset;
  logic [M-1:0]      m_cyc, m_stb, m_we;
  logic [M*AW-1:0]   m_adr;
  logic [M*DW-1:0]   m_dat;
  logic [M*SW-1:0]   m_sel;
  logic [DW-1:0]     m_dat_o;
  logic [M-1:0]      m_ack, m_err, grant;
  logic              s_cyc, s_stb, s_we;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_o;
  logic [SW-1:0]     s_sel;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack, s_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          stb;
    logic          ack;
    logic          err;
    logic [DW-1:0] sdat;
    logic [M-1:0]  exp_ack;
    logic [M-1:0]  exp_err;
    logic          exp_stb;
  } vec_t;

  vec_t vecs[6];

  peripheral_arbiter_wb #(.MASTERS(M), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .aclk(aclk), .areset(areset),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [M-1:0] oh(input int i);
    return M'(1) << i;
  endfunction

  // Reference arbitration: walk the masters in circular order starting just
  // after the previous owner and take the first one that is requesting.
  function automatic int rr_pick(input int last, input logic [M-1:0] req);
    logic [1:0] idx;
    for (int k = 1; k <= M; k++) begin
      idx = 2'((last + k) % M);
      if (req[idx]) return int'(idx);
    end
    return -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exceeded");
  end

  initial begin
    int hit;
    int mlast;
    int own;
    int beats;
    int done;
    logic [M-1:0] req;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h11111111, 4'h0, 4'h0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'hCAFEF00D, 4'h8, 4'h0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 4'h0, 4'h8, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 4'h0, 4'h8, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 4'h0, 4'h0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h12345678, 4'h8, 4'h0, 1'b1};

    // Reset with every input pushing activity.
    areset  = 1'b1;
    m_cyc   = 4'hF;
    m_stb   = 4'hF;
    m_we    = 4'h0;
    m_adr   = '0;
    m_dat   = '0;
    m_sel   = '0;
    s_dat_i = 32'h5A5A0F0F;
    s_ack   = 1'b1;
    s_err   = 1'b1;
    tick();
    tick();
    settle();
    check("rst_grant", grant, 0);
    check("rst_scyc", s_cyc, 0);
    check("rst_sstb", s_stb, 0);
    check("rst_ack", m_ack, 0);
    check("rst_err", m_err, 0);
    check("rst_mdat", m_dat_o, 32'h5A5A0F0F);

    // All four request: grants 0,1,2,3,0 with an idle cycle between owners.
    areset = 1'b0;
    s_ack  = 1'b0;
    s_err  = 1'b0;
    m_stb  = 4'h0;
    m_cyc  = 4'hF;
    for (int n = 0; n < 5; n++) begin
      tick();
      settle();
      check("rr_grant", grant, oh(n % 4));
      m_cyc = 4'hF & ~oh(n % 4);
      tick();
      settle();
      check("rr_idle", grant, 0);
      m_cyc = (n < 4) ? 4'hF : 4'h0;
    end

    // Master 2 bursts four beats while master 1 waits.
    m_cyc = 4'b0100;
    tick();
    settle();
    check("burst_grant", grant, 4'b0100);
    m_cyc = 4'b0110;
    m_stb = 4'b0100;
    s_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      settle();
      check("burst_hold", grant, 4'b0100);
      check("burst_ack", m_ack, 4'b0100);
      tick();
    end
    m_cyc = 4'b0010;
    m_stb = 4'b0000;
    s_ack = 1'b0;
    settle();
    tick();
    settle();
    check("burst_idle", grant, 0);
    tick();
    settle();
    check("burst_next", grant, 4'b0010);
    m_cyc = 4'b0000;
    tick();
    settle();
    check("burst_release", grant, 0);

    // Master 3 write passes through unchanged; then the response table.
    for (int i = 0; i < M; i++) begin
      m_adr[i*AW +: AW] = $urandom;
      m_dat[i*DW +: DW] = $urandom;
      m_sel[i*SW +: SW] = SW'($urandom);
    end
    m_adr[3*AW +: AW] = 32'h00001000;
    m_dat[3*DW +: DW] = 32'hDEADBEEF;
    m_sel[3*SW +: SW] = 4'hF;
    m_we  = 4'b1000;
    m_cyc = 4'b1000;
    tick();
    settle();
    check("wr_grant", grant, 4'b1000);
    m_stb = 4'b1000;
    s_ack = 1'b1;
    settle();
    check("wr_adr", s_adr, 32'h00001000);
    check("wr_dat", s_dat_o, 32'hDEADBEEF);
    check("wr_sel", s_sel, 4'hF);
    check("wr_we", s_we, 1);
    check("wr_cyc", s_cyc, 1);
    check("wr_stb", s_stb, 1);
    check("wr_ack", m_ack, 4'b1000);
    for (int i = 0; i < 6; i++) begin
      tick();
      m_stb   = vecs[i].stb ? 4'b1000 : 4'b0000;
      s_ack   = vecs[i].ack;
      s_err   = vecs[i].err;
      s_dat_i = vecs[i].sdat;
      settle();
      check("vec_ack", m_ack, vecs[i].exp_ack);
      check("vec_err", m_err, vecs[i].exp_err);
      check("vec_sstb", s_stb, vecs[i].exp_stb);
      check("vec_mdat", m_dat_o, vecs[i].sdat);
    end
    tick();
    m_cyc = 4'b0000;
    m_stb = 4'b0000;
    s_ack = 1'b0;
    s_err = 1'b0;
    tick();
    settle();
    check("wr_release", grant, 0);

    // Watchdog: master 0 strobes and the slave stays silent.
    m_cyc = 4'b0001;
    tick();
    settle();
    check("wd_grant", grant, 4'b0001);
    m_stb = 4'b0001;
    hit = -1;
    for (int n = 0; n <= 300; n++) begin
      if (n > 0) tick();
      settle();
      if (m_err !== 4'b0000) begin
        hit = n;
        break;
      end
    end
    check("wd_cycles", hit, TO);
    check("wd_err_owner", m_err, 4'b0001);
    check("wd_scyc", s_cyc, 0);
    tick();
    settle();
    check("wd_idle", grant, 0);
    check("wd_err_pulse", m_err, 0);
    m_cyc = 4'b0000;
    m_stb = 4'b0000;
    tick();
    settle();

    // Reset while master 1 owns the bus.
    m_cyc = 4'b0010;
    tick();
    settle();
    check("rst_mid_grant", grant, 4'b0010);
    m_stb = 4'b0010;
    tick();
    areset = 1'b1;
    m_cyc  = 4'hF;
    s_ack  = 1'b1;
    settle();
    check("rst_mid_ack", m_ack, 0);
    check("rst_mid_scyc", s_cyc, 0);
    tick();
    settle();
    check("rst_mid_grant0", grant, 0);
    check("rst_mid_scyc2", s_cyc, 0);
    areset = 1'b0;
    s_ack  = 1'b0;
    m_stb  = 4'b0000;
    tick();
    settle();
    check("rst_mid_next", grant, 4'b0001);
    m_cyc = 4'b0000;
    tick();
    settle();
    check("rst_mid_release", grant, 0);

    // Randomized transactions checked against the reference model.
    areset = 1'b1;
    m_cyc  = '0;
    m_stb  = '0;
    s_ack  = 1'b0;
    s_err  = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    mlast  = M - 1;
    for (int t = 0; t < 30; t++) begin
      req = M'($urandom_range(1, 2**M - 1));
      for (int i = 0; i < M; i++) begin
        m_adr[i*AW +: AW] = $urandom;
        m_dat[i*DW +: DW] = $urandom;
        m_sel[i*SW +: SW] = SW'($urandom);
      end
      m_we  = M'($urandom);
      m_cyc = req;
      m_stb = '0;
      own   = rr_pick(mlast, req);
      tick();
      settle();
      check("rand_grant", grant, oh(own));
      beats = $urandom_range(1, 3);
      done  = 0;
      for (int c = 0; c < 20 && done < beats; c++) begin
        tick();
        m_cyc   = M'($urandom) | oh(own);
        m_stb   = oh(own);
        s_dat_i = $urandom;
        s_ack   = (c >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        s_err   = ($urandom_range(0, 7) == 0);
        settle();
        check("rand_hold", grant, oh(own));
        check("rand_scyc", s_cyc, 1);
        check("rand_adr", s_adr, m_adr[own*AW +: AW]);
        check("rand_dat", s_dat_o, m_dat[own*DW +: DW]);
        check("rand_sel", s_sel, m_sel[own*SW +: SW]);
        check("rand_we", s_we, m_we[own]);
        check("rand_ack", m_ack, (s_ack && !s_err) ? oh(own) : '0);
        check("rand_err", m_err, s_err ? oh(own) : '0);
        check("rand_mdat", m_dat_o, s_dat_i);
        if (s_ack || s_err) done++;
      end
      tick();
      m_cyc = M'($urandom) & ~oh(own);
      m_stb = '0;
      s_ack = 1'b0;
      s_err = 1'b0;
      tick();
      settle();
      check("rand_release", grant, 0);
      mlast = own;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
